// File: rtl/starforce_input_ctrl.sv
// starforce_input_ctrl: merges PS/2 keys and pads, debounces each control bit,
// suppresses opposing directions and turns a coin press into one timed pulse.
module starforce_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned COIN_PULSE_CYCLES = 2400000,
    parameter int unsigned COIN_GAP_CYCLES   = 2400000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    output logic [6:0]  UDLRTSC
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_state_e;

    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD   = 24'(COIN_GAP_CYCLES - 1);

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    logic        tog_q, armed_q, key_evt;
    logic [7:0]  keys_q, keys_d;
    logic [6:0]  raw, db_q;
    logic [15:0] db_cnt_q [7];
    coin_state_e state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        unused_pads;

    // Assert asynchronously, release two clean edges later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign key_evt = armed_q && (ps2_key[10] != tog_q);

    // keys: {up, down, left, right, trig, f1, key1, key5}
    always_comb begin
        keys_d = keys_q;
        if (key_evt) begin
            case (ps2_key[7:0])
                8'h75: keys_d[7] = ps2_key[9];
                8'h72: keys_d[6] = ps2_key[9];
                8'h6B: keys_d[5] = ps2_key[9];
                8'h74: keys_d[4] = ps2_key[9];
                8'h14: if (!ps2_key[8]) keys_d[3] = ps2_key[9];
                8'h05: if (!ps2_key[8]) keys_d[2] = ps2_key[9];
                8'h16: if (!ps2_key[8]) keys_d[1] = ps2_key[9];
                8'h2E: if (!ps2_key[8]) keys_d[0] = ps2_key[9];
                default: ;
            endcase
        end
    end

    assign raw = {keys_q[7] | joystk1[3], keys_q[6] | joystk1[2],
                  keys_q[5] | joystk1[1], keys_q[4] | joystk1[0],
                  keys_q[3] | joystk1[4],
                  keys_q[2] | keys_q[1] | joystk1[6] | joystk2[6],
                  keys_q[2] | keys_q[0] | joystk1[8]};

    assign unused_pads = ^{joystk1[15:9], joystk1[7], joystk1[5], joystk2[15:7], joystk2[5:0]};

    // IDLE is only entered with coin low, so coin high here is a fresh rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (db_q[0]) begin
                state_d = PULSE;
                cnt_d   = PULSE_LOAD;
            end
            PULSE: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = GAP_LOAD;
            end else cnt_d = cnt_q - 24'd1;
            GAP: if (cnt_q == '0) state_d = db_q[0] ? WAIT_REL : IDLE;
                 else cnt_d = cnt_q - 24'd1;
            WAIT_REL: if (!db_q[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            keys_q  <= '0;
            db_q    <= '0;
            for (int b = 0; b < 7; b++) db_cnt_q[b] <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            keys_q  <= keys_d;
            for (int b = 0; b < 7; b++) begin
                if (raw[b] == db_q[b]) db_cnt_q[b] <= '0;
                else if (db_cnt_q[b] == DB_LAST) begin
                    db_cnt_q[b] <= '0;
                    db_q[b]     <= raw[b];
                end else db_cnt_q[b] <= db_cnt_q[b] + 16'd1;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign UDLRTSC = {db_q[6] & ~db_q[5], db_q[5] & ~db_q[6],
                      db_q[4] & ~db_q[3], db_q[3] & ~db_q[4],
                      db_q[2:1], state_q == PULSE};
endmodule

// File: doc/starforce_input_ctrl.md
STARFORCE_INPUT_CTRL -- requirements
Module: starforce_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive differing samples required before a debounced input changes; legal range 1..65535.
REQ-002 Parameter COIN_PULSE_CYCLES, default 2400000: length of the coin pulse on UDLRTSC[0]; legal range 1..2^24-1.
REQ-003 Parameter COIN_GAP_CYCLES, default 2400000: minimum coin dead time after a pulse; legal range 1..2^24-1.
REQ-004 clk_sys  in  1  system clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-007 joystk1  in  16  player-1 pad, active high: [0] right, [1] left, [2] down, [3] up, [4] fire, [6] start1, [7] start2, [8] coin.
REQ-008 joystk2  in  16  player-2 pad, active high; only [6] start1 and [7] start2 are used.
REQ-009 UDLRTSC  out  7  active-high, bit order {up, down, left, right, trig, start, coin}, driving the game core controls.

Function
REQ-010 A key event SHALL be detected when ps2_key[10] differs from its registered copy.
REQ-011 The first edge after reset SHALL only load the toggle copy and SHALL NOT decode a key event.
REQ-012 On a key event, the key flag for the decoded code SHALL be loaded with ps2_key[9].
REQ-013 Arrow codes SHALL ignore bit 8: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
REQ-014 Remaining codes SHALL require bit 8 = 0: 0x014 trig, 0x005 F1, 0x006 F2, 0x016 key1, 0x01E key2, 0x02E key5.
REQ-015 Unmapped codes SHALL change no state.
REQ-016 The raw vector SHALL be the combinational OR merge of key flags and pads:
- up = key_up|joystk1[3]; down = key_down|joystk1[2]; left = key_left|joystk1[1]; right = key_right|joystk1[0]; trig = key_trig|joystk1[4]
- start = F1|key1|joystk1[6]|joystk2[6]
- coin = F1|key5|joystk1[8]
- F2, key2, joystk1[7] and joystk2[7] SHALL have no effect on UDLRTSC.
REQ-017 Each of the 7 raw bits SHALL have its own debouncer.
- Its counter increments on every edge at which raw differs from the debounced value.
- The counter clears to 0 on any edge at which they match.
- The debounced bit takes the raw value at the DEBOUNCE_CYCLES-th consecutive differing edge, and its counter clears on that edge.
REQ-018 Latency: a pad change sampled first at edge k SHALL appear on the debounced bit after edge k+DEBOUNCE_CYCLES-1; keyboard changes take one edge longer.
REQ-019 Opposing-direction suppression:
- If debounced up and down are both 1, UDLRTSC[6] and [5] SHALL both be 0.
- Likewise left/right on [4] and [3].
REQ-020 UDLRTSC[6:1] SHALL be combinational from the registered debounced bits after REQ-019; no extra register stage.
REQ-021 Coin FSM states: IDLE, PULSE, GAP, WAIT_REL. UDLRTSC[0] SHALL be 1 only in PULSE.
REQ-022 IDLE -> PULSE on the edge after debounced coin rises (0 to 1); the counter loads COIN_PULSE_CYCLES-1.
REQ-023 PULSE SHALL last exactly COIN_PULSE_CYCLES edges, then move to GAP for exactly COIN_GAP_CYCLES edges.
REQ-024 Leaving GAP, the FSM SHALL go to WAIT_REL if debounced coin is 1, else to IDLE; WAIT_REL -> IDLE when debounced coin is 0.
REQ-025 Coin rises during PULSE, GAP or WAIT_REL SHALL be ignored: no retrigger, no queuing.
REQ-026 A held coin SHALL produce exactly one pulse.
REQ-027 Coin counter width SHALL be 24 bits; debounce counters 16 bits.
REQ-028 Neither counter SHALL wrap, for any legal parameter value.

Reset
REQ-029 On reset_n low, all of the following SHALL clear asynchronously to 0 / initial state: key flags, toggle copy, first-edge flag, debounce counters and bits, coin FSM (IDLE) and coin counter.
- UDLRTSC SHALL read 7'b0 while reset_n is low.
REQ-030 Reset mid-pulse SHALL drop UDLRTSC[0] immediately; after release, the coin bit must debounce from 0 again before a new pulse.
REQ-031 Reset release SHALL be synchronised internally so that state leaves reset on a clean clk_sys edge.

Verification (DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=8, COIN_GAP_CYCLES=6)
REQ-032 joystk1[3] 0->1 held, first sampled at edge 10 -> UDLRTSC[6]=1 after edge 13; a 3-edge glitch -> no change.
REQ-033 ps2_key toggles with pressed=1, code 0x175 -> up=1 one edge later than the pad case; release event with code 0x075 -> up returns to 0.
REQ-034 joystk1[3] and joystk1[2] both held -> UDLRTSC[6:5]=00; release down -> UDLRTSC[6:5]=10 after 4 edges.
REQ-035 Coin held for 40 edges -> UDLRTSC[0] high for exactly 8 edges, then one pulse only.
- Release, then press again during GAP -> ignored.
- Press after return to IDLE -> second 8-edge pulse.
REQ-036 Assert reset_n low at pulse edge 3 -> UDLRTSC=0 immediately; ps2_key[10]=1 at reset release -> no spurious key event.
REQ-037 F1 key press -> start and coin both set; F2, code 0x01E, joystk2[7] -> UDLRTSC unchanged.
